// File: rtl/systolic_gemm_tile_if.sv
`default_nettype none
// ============================================================================
// Module   : systolic_gemm_tile_if
// Desc     : Bundle of the tile-control, operand-stream and result-stream
//            signals of systolic_gemm_tile. The master drives commands and
//            operands; the slave (the tile) returns readiness and results.
// Revision : 1.0 - initial release
// ============================================================================
interface systolic_gemm_tile_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int K_MAX      = 255
);
    localparam int c_kw = $clog2(K_MAX + 1);
    localparam int c_rw = (ROWS > 1) ? $clog2(ROWS) : 1;

    // tile command
    logic                       start;
    logic [c_kw-1:0]            k_len;
    logic                       acc_mode;
    logic                       signed_mode;

    // operand stream
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_WIDTH*ROWS-1:0] a_col;
    logic [DATA_WIDTH*COLS-1:0] b_row;

    // result stream
    logic                       out_valid;
    logic                       out_ready;
    logic [ACC_WIDTH*COLS-1:0]  out_row;
    logic [c_rw-1:0]            out_row_idx;

    // status
    logic                       busy;
    logic                       done;

    modport master (
        output start, k_len, acc_mode, signed_mode,
        output in_valid, a_col, b_row, out_ready,
        input  in_ready, out_valid, out_row, out_row_idx, busy, done
    );

    modport slave (
        input  start, k_len, acc_mode, signed_mode,
        input  in_valid, a_col, b_row, out_ready,
        output in_ready, out_valid, out_row, out_row_idx, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/systolic_gemm_tile.sv
`default_nettype none
// ============================================================================
// Module   : systolic_gemm_tile
// Desc     : Output-stationary ROWS x COLS multiply-accumulate array with
//            built-in input skew. Takes K beats of A columns / B rows over a
//            valid/ready stream, flushes the wavefront with zero operands,
//            then drains the result matrix one row per handshake.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_gemm_tile #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int K_MAX      = 255
) (
    input  wire logic           clk,
    input  wire logic           rst,
    systolic_gemm_tile_if.slave bus
);
    localparam int c_kw = $clog2(K_MAX + 1);
    localparam int c_rw = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_fw = $clog2(ROWS + COLS);
    // operand extension width up to the accumulator width
    localparam int c_xw = ACC_WIDTH - DATA_WIDTH;
    localparam logic [c_fw-1:0] c_flush_last = c_fw'(ROWS + COLS - 2);
    localparam logic [c_rw-1:0] c_row_last   = c_rw'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [c_kw-1:0] r_k_len;
    logic [c_kw-1:0] r_beat;
    logic [c_fw-1:0] r_flush;
    logic [c_rw-1:0] r_row;
    logic            r_signed;
    logic            r_done;

    logic w_in_hs;
    logic w_out_hs;
    logic w_last_beat;
    logic w_last_row;
    logic w_step;
    logic w_clear;

    // operands entering the skew chains, and operands arriving at each PE
    logic [DATA_WIDTH-1:0] w_feed_a [ROWS];
    logic [DATA_WIDTH-1:0] w_feed_b [COLS];
    logic [DATA_WIDTH-1:0] w_a_in   [ROWS][COLS];
    logic [DATA_WIDTH-1:0] w_b_in   [ROWS][COLS];
    logic [ACC_WIDTH-1:0]  w_acc    [ROWS][COLS];
    logic [ACC_WIDTH*COLS-1:0] w_out_row;

    assign w_in_hs     = (r_state == S_LOAD) && bus.in_valid;
    assign w_out_hs    = (r_state == S_DRAIN) && bus.out_ready;
    assign w_last_beat = (r_beat == (r_k_len - c_kw'(1)));
    assign w_last_row  = (r_row == c_row_last);
    // the whole array (skew, pass registers, accumulators) moves only on a step,
    // so a stalled input stream freezes the wavefront instead of inserting bubbles
    assign w_step      = w_in_hs || (r_state == S_FLUSH);
    // a fresh (non-accumulating) tile wipes the accumulators on its start cycle
    assign w_clear     = (r_state == S_IDLE) && bus.start && !bus.acc_mode;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.k_len != '0) ? S_LOAD : S_DRAIN;
                end
            end
            S_LOAD: begin
                if (w_in_hs && w_last_beat) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (r_flush == c_flush_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_out_hs && w_last_row) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // tile configuration latch, beat/flush/row counters and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k_len  <= '0;
            r_signed <= 1'b0;
            r_beat   <= '0;
            r_flush  <= '0;
            r_row    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_out_hs && w_last_row;
            case (r_state)
                S_IDLE: begin
                    r_beat  <= '0;
                    r_flush <= '0;
                    r_row   <= '0;
                    if (bus.start) begin
                        r_k_len  <= bus.k_len;
                        r_signed <= bus.signed_mode;
                    end
                end
                S_LOAD: begin
                    if (w_in_hs) begin
                        r_beat <= r_beat + c_kw'(1);
                    end
                end
                S_FLUSH: begin
                    r_flush <= r_flush + c_fw'(1);
                end
                S_DRAIN: begin
                    if (w_out_hs) begin
                        r_row <= w_last_row ? '0 : (r_row + c_rw'(1));
                    end
                end
                default: ;
            endcase
        end
    end

    // edge operands: live stream data while loading, zeros while flushing
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            w_feed_a[i] = (r_state == S_LOAD) ? bus.a_col[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
        for (int j = 0; j < COLS; j++) begin
            w_feed_b[j] = (r_state == S_LOAD) ? bus.b_row[j*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    end

    // row i of A is delayed i steps before entering column 0
    for (genvar i = 0; i < ROWS; i++) begin : g_skew_a
        if (i == 0) begin : g_direct
            assign w_a_in[i][0] = w_feed_a[i];
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] r_sh [i];
            // shift chain advancing with the array
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < i; s++) begin
                        r_sh[s] <= '0;
                    end
                end else if (w_step) begin
                    r_sh[0] <= w_feed_a[i];
                    for (int s = 1; s < i; s++) begin
                        r_sh[s] <= r_sh[s-1];
                    end
                end
            end
            assign w_a_in[i][0] = r_sh[i-1];
        end
    end

    // column j of B is delayed j steps before entering row 0
    for (genvar j = 0; j < COLS; j++) begin : g_skew_b
        if (j == 0) begin : g_direct
            assign w_b_in[0][j] = w_feed_b[j];
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] r_sh [j];
            // shift chain advancing with the array
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < j; s++) begin
                        r_sh[s] <= '0;
                    end
                end else if (w_step) begin
                    r_sh[0] <= w_feed_b[j];
                    for (int s = 1; s < j; s++) begin
                        r_sh[s] <= r_sh[s-1];
                    end
                end
            end
            assign w_b_in[0][j] = r_sh[j-1];
        end
    end

    // processing elements: A moves right, B moves down, C stays put
    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            logic [ACC_WIDTH-1:0] r_acc;
            logic [ACC_WIDTH-1:0] w_a_x;
            logic [ACC_WIDTH-1:0] w_b_x;
            logic [ACC_WIDTH-1:0] w_prod;

            // extending both operands to ACC_WIDTH first makes the low
            // ACC_WIDTH bits of the product exact for either signedness
            assign w_a_x  = {{c_xw{r_signed & w_a_in[i][j][DATA_WIDTH-1]}}, w_a_in[i][j]};
            assign w_b_x  = {{c_xw{r_signed & w_b_in[i][j][DATA_WIDTH-1]}}, w_b_in[i][j]};
            assign w_prod = w_a_x * w_b_x;

            // wrapping accumulate on every array step
            always_ff @(posedge clk) begin
                if (rst || w_clear) begin
                    r_acc <= '0;
                end else if (w_step) begin
                    r_acc <= r_acc + w_prod;
                end
            end
            assign w_acc[i][j] = r_acc;

            if (j < COLS - 1) begin : g_pass_a
                logic [DATA_WIDTH-1:0] r_a;
                // forward A to the right-hand neighbour
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_a <= '0;
                    end else if (w_step) begin
                        r_a <= w_a_in[i][j];
                    end
                end
                assign w_a_in[i][j+1] = r_a;
            end

            if (i < ROWS - 1) begin : g_pass_b
                logic [DATA_WIDTH-1:0] r_b;
                // forward B to the neighbour below
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_b <= '0;
                    end else if (w_step) begin
                        r_b <= w_b_in[i][j];
                    end
                end
                assign w_b_in[i+1][j] = r_b;
            end
        end
    end

    // result row select; forced to zero outside the drain phase
    always_comb begin
        w_out_row = '0;
        if (r_state == S_DRAIN) begin
            for (int j = 0; j < COLS; j++) begin
                w_out_row[j*ACC_WIDTH +: ACC_WIDTH] = w_acc[r_row][j];
            end
        end
    end

    assign bus.in_ready    = (r_state == S_LOAD);
    assign bus.out_valid   = (r_state == S_DRAIN);
    assign bus.out_row     = w_out_row;
    assign bus.out_row_idx = r_row;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = r_done;
endmodule
`default_nettype wire

// File: tb/tb_systolic_gemm_tile.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_gemm_tile
// Desc     : Directed self-checking bench for systolic_gemm_tile (4x4 array,
//            32-bit accumulators, plus a 16-bit accumulator instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_gemm_tile;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int KM = 255;
    localparam logic [31:0] c_ramp = 32'h04030201;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    // edge counter used for latency measurements
    always @(posedge clk) cyc <= cyc + 1;

    systolic_gemm_tile_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ROWS(R), .COLS(C), .K_MAX(KM)) bus ();
    systolic_gemm_tile #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ROWS(R), .COLS(C), .K_MAX(KM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    systolic_gemm_tile_if #(.DATA_WIDTH(DW), .ACC_WIDTH(16), .ROWS(R), .COLS(C), .K_MAX(KM)) bus16 ();
    systolic_gemm_tile #(.DATA_WIDTH(DW), .ACC_WIDTH(16), .ROWS(R), .COLS(C), .K_MAX(KM)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    logic [31:0] res [R][C];
    int first_valid_cyc;
    int last_row_cyc;
    int last_hs_cyc;
    int unstable;
    int order_err;
    bit timeout;
    bit done_after;
    bit busy_after;
    bit done_next;

    task automatic start_tile(input int k, input bit acc, input bit sgn);
        timeout         = 1'b0;
        bus.k_len       = 8'(k);
        bus.acc_mode    = acc;
        bus.signed_mode = sgn;
        bus.start       = 1'b1;
        @(posedge clk); #1;
        bus.start       = 1'b0;
    endtask

    // feeds k beats; optionally stalls on alternate cycles and pulses a stray start
    task automatic feed(input int k, input logic [31:0] a, input logic [31:0] b,
                        input bit stall, input int pulse_at);
        int sent = 0;
        int guard = 0;
        bit hs;
        bit pulsed = 1'b0;
        while (sent < k && guard < 100) begin
            bus.in_valid = stall ? (guard % 2 == 1) : 1'b1;
            bus.a_col    = a;
            bus.b_row    = b;
            if (sent == pulse_at && !pulsed) begin
                bus.start    = 1'b1;
                bus.k_len    = 8'd1;
                bus.acc_mode = 1'b0;
                pulsed       = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            guard++;
            if (hs) begin
                sent++;
                last_hs_cyc = cyc;
            end
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        bus.a_col    = '0;
        bus.b_row    = '0;
        if (sent < k) timeout = 1'b1;
    endtask

    // collects four rows, recording order errors and instability under back-pressure
    task automatic drain(input bit rand_ready);
        int guard = 0;
        int next_row = 0;
        int rows_seen = 0;
        bit hs;
        bit prev_pending = 1'b0;
        logic [AW*C-1:0] prev_row = '0;
        logic [1:0] prev_idx = '0;
        unstable  = 0;
        order_err = 0;
        while (!bus.out_valid && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        first_valid_cyc = cyc;
        while (rows_seen < R && guard < 400) begin
            if (prev_pending && (bus.out_row !== prev_row || bus.out_row_idx !== prev_idx)) unstable++;
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            hs           = bus.out_valid && bus.out_ready;
            prev_row     = bus.out_row;
            prev_idx     = bus.out_row_idx;
            prev_pending = bus.out_valid && !bus.out_ready;
            if (hs) begin
                if (bus.out_row_idx !== 2'(next_row)) order_err++;
                for (int j = 0; j < C; j++) res[next_row][j] = bus.out_row[j*AW +: AW];
                next_row++;
                rows_seen++;
            end
            @(posedge clk); #1;
            guard++;
            if (hs && rows_seen == R) last_row_cyc = cyc;
        end
        if (rows_seen < R) timeout = 1'b1;
        done_after    = bus.done;
        busy_after    = bus.busy;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        done_next = bus.done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.out_row !== '0) $display("FAIL reset_out_row: got %h want 0", bus.out_row); else n_pass++;
        n_total++; if (bus.out_row_idx !== 2'd0) $display("FAIL reset_out_row_idx: got %0d want 0", bus.out_row_idx); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else n_pass++;
        n_total++; if (bus16.busy !== 1'b0) $display("FAIL reset_busy16: got %b want 0", bus16.busy); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ramp();
        start_tile(4, 1'b0, 1'b0);
        n_total++; if (bus.busy !== 1'b1) $display("FAIL ramp_busy_after_start: got %b want 1", bus.busy); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL ramp_in_ready_after_start: got %b want 1", bus.in_ready); else n_pass++;
        feed(4, c_ramp, c_ramp, 1'b0, -1);
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL ramp_in_ready_after_last: got %b want 0", bus.in_ready); else n_pass++;
        drain(1'b0);
        n_total++; if (timeout !== 1'b0) $display("FAIL ramp_timeout: got %b want 0", timeout); else n_pass++;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                n_total++;
                if (res[i][j] !== 32'(4 * (i + 1) * (j + 1)))
                    $display("FAIL ramp_c[%0d][%0d]: got %0d want %0d", i, j, res[i][j], 4 * (i + 1) * (j + 1));
                else n_pass++;
            end
        // out_valid rises at the 7th edge after the last-beat edge, i.e. in cycle t+8
        n_total++; if (first_valid_cyc - last_hs_cyc !== 7) $display("FAIL ramp_valid_latency: got %0d want 7", first_valid_cyc - last_hs_cyc); else n_pass++;
        n_total++; if (last_row_cyc - first_valid_cyc !== 4) $display("FAIL ramp_done_latency: got %0d want 4", last_row_cyc - first_valid_cyc); else n_pass++;
        n_total++; if (done_after !== 1'b1) $display("FAIL ramp_done_pulse: got %b want 1", done_after); else n_pass++;
        n_total++; if (busy_after !== 1'b0) $display("FAIL ramp_busy_end: got %b want 0", busy_after); else n_pass++;
        n_total++; if (done_next !== 1'b0) $display("FAIL ramp_done_one_cycle: got %b want 0", done_next); else n_pass++;
        n_total++; if (order_err !== 0) $display("FAIL ramp_row_order: got %0d errors want 0", order_err); else n_pass++;
    endtask

    task automatic test_signed();
        start_tile(2, 1'b0, 1'b1);
        feed(2, 32'hFDFDFDFD, 32'h05050505, 1'b0, -1);
        drain(1'b0);
        n_total++; if (timeout !== 1'b0) $display("FAIL signed_timeout: got %b want 0", timeout); else n_pass++;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                n_total++;
                if (res[i][j] !== 32'hFFFFFFE2) $display("FAIL signed_c[%0d][%0d]: got %h want ffffffe2", i, j, res[i][j]);
                else n_pass++;
            end
        start_tile(2, 1'b0, 1'b0);
        feed(2, 32'hFDFDFDFD, 32'h05050505, 1'b0, -1);
        drain(1'b0);
        n_total++; if (timeout !== 1'b0) $display("FAIL unsigned_timeout: got %b want 0", timeout); else n_pass++;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                n_total++;
                if (res[i][j] !== 32'd2530) $display("FAIL unsigned_c[%0d][%0d]: got %0d want 2530", i, j, res[i][j]);
                else n_pass++;
            end
    endtask

    task automatic test_stalls();
        start_tile(4, 1'b0, 1'b0);
        feed(4, c_ramp, c_ramp, 1'b1, -1);
        drain(1'b1);
        n_total++; if (timeout !== 1'b0) $display("FAIL stall_timeout: got %b want 0", timeout); else n_pass++;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                n_total++;
                if (res[i][j] !== 32'(4 * (i + 1) * (j + 1)))
                    $display("FAIL stall_c[%0d][%0d]: got %0d want %0d", i, j, res[i][j], 4 * (i + 1) * (j + 1));
                else n_pass++;
            end
        n_total++; if (first_valid_cyc - last_hs_cyc !== 7) $display("FAIL stall_valid_latency: got %0d want 7", first_valid_cyc - last_hs_cyc); else n_pass++;
        n_total++; if (unstable !== 0) $display("FAIL stall_row_stability: got %0d changes want 0", unstable); else n_pass++;
        n_total++; if (order_err !== 0) $display("FAIL stall_row_order: got %0d errors want 0", order_err); else n_pass++;
    endtask

    task automatic test_accumulate();
        start_tile(4, 1'b0, 1'b0);
        feed(4, c_ramp, c_ramp, 1'b0, -1);
        drain(1'b0);
        start_tile(4, 1'b1, 1'b0);
        // stray start (with k_len=1, acc_mode=0) while loading must be ignored
        feed(4, c_ramp, c_ramp, 1'b0, 2);
        drain(1'b0);
        n_total++; if (timeout !== 1'b0) $display("FAIL acc_timeout: got %b want 0", timeout); else n_pass++;
        n_total++; if (res[3][3] !== 32'd128) $display("FAIL acc_c33: got %0d want 128", res[3][3]); else n_pass++;
        n_total++; if (res[0][0] !== 32'd8) $display("FAIL acc_c00: got %0d want 8", res[0][0]); else n_pass++;
        n_total++; if (res[1][2] !== 32'd48) $display("FAIL acc_c12: got %0d want 48", res[1][2]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        start_tile(4, 1'b0, 1'b0);
        feed(2, c_ramp, c_ramp, 1'b0, -1);
        rst = 1'b1;
        @(posedge clk); #1;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL rstmid_in_ready: got %b want 0", bus.in_ready); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        start_tile(4, 1'b1, 1'b0);
        feed(4, c_ramp, c_ramp, 1'b0, -1);
        drain(1'b0);
        n_total++; if (timeout !== 1'b0) $display("FAIL rstmid_timeout: got %b want 0", timeout); else n_pass++;
        n_total++; if (res[3][3] !== 32'd64) $display("FAIL rstmid_c33: got %0d want 64", res[3][3]); else n_pass++;
        n_total++; if (res[0][1] !== 32'd8) $display("FAIL rstmid_c01: got %0d want 8", res[0][1]); else n_pass++;
    endtask

    task automatic test_empty();
        start_tile(0, 1'b0, 1'b0);
        n_total++; if (bus.out_valid !== 1'b1) $display("FAIL empty_valid_next_cycle: got %b want 1", bus.out_valid); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL empty_in_ready: got %b want 0", bus.in_ready); else n_pass++;
        drain(1'b0);
        n_total++; if (timeout !== 1'b0) $display("FAIL empty_timeout: got %b want 0", timeout); else n_pass++;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                n_total++;
                if (res[i][j] !== 32'd0) $display("FAIL empty_c[%0d][%0d]: got %0d want 0", i, j, res[i][j]);
                else n_pass++;
            end
        n_total++; if (done_after !== 1'b1) $display("FAIL empty_done: got %b want 1", done_after); else n_pass++;
    endtask

    task automatic test_wrap();
        int guard = 0;
        int sent = 0;
        int got = 0;
        bit hs;
        logic [15:0] r16 [R][C];
        bus16.k_len       = 8'd2;
        bus16.acc_mode    = 1'b0;
        bus16.signed_mode = 1'b0;
        bus16.start       = 1'b1;
        @(posedge clk); #1;
        bus16.start    = 1'b0;
        bus16.a_col    = 32'hFFFFFFFF;
        bus16.b_row    = 32'hFFFFFFFF;
        bus16.in_valid = 1'b1;
        while (sent < 2 && guard < 50) begin
            hs = bus16.in_valid && bus16.in_ready;
            @(posedge clk); #1;
            guard++;
            if (hs) sent++;
        end
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        while (got < R && guard < 100) begin
            hs = bus16.out_valid;
            if (hs) for (int j = 0; j < C; j++) r16[got][j] = bus16.out_row[j*16 +: 16];
            @(posedge clk); #1;
            guard++;
            if (hs) got++;
        end
        bus16.out_ready = 1'b0;
        n_total++; if (got !== R) $display("FAIL wrap_rows: got %0d want %0d", got, R); else n_pass++;
        for (int i = 0; i < got; i++)
            for (int j = 0; j < C; j++) begin
                n_total++;
                if (r16[i][j] !== 16'd64514) $display("FAIL wrap_c[%0d][%0d]: got %0d want 64514", i, j, r16[i][j]);
                else n_pass++;
            end
    endtask

    initial begin
        rst               = 1'b1;
        bus.start         = 1'b0;
        bus.k_len         = '0;
        bus.acc_mode      = 1'b0;
        bus.signed_mode   = 1'b0;
        bus.in_valid      = 1'b0;
        bus.a_col         = '0;
        bus.b_row         = '0;
        bus.out_ready     = 1'b0;
        bus16.start       = 1'b0;
        bus16.k_len       = '0;
        bus16.acc_mode    = 1'b0;
        bus16.signed_mode = 1'b0;
        bus16.in_valid    = 1'b0;
        bus16.a_col       = '0;
        bus16.b_row       = '0;
        bus16.out_ready   = 1'b0;
        #1;
        test_reset();
        test_ramp();
        test_signed();
        test_stalls();
        test_accumulate();
        test_reset_mid();
        test_empty();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/systolic_gemm_tile.md
# systolic_gemm_tile

Output-stationary ROWS×COLS signed/unsigned multiply-accumulate tile with the input skew registers built in. It accepts a K-beat stream of A columns and B rows over a valid/ready handshake, then flushes the wavefront. It then drains the result matrix one row per handshake. It succeeds the fixed-size enable-driven array with these additions: runtime K, stall tolerance, accumulate-across-tiles mode, selectable signedness and back-pressured result readout.

## Interface
- DATA_WIDTH, 8, operand width
- ACC_WIDTH, 32, accumulator/result width (≥ 2*DATA_WIDTH)
- ROWS, 8, array rows (≥ 1)
- COLS, 8, array columns (≥ 1)
- K_MAX, 255, maximum beats per tile; KW = $clog2(K_MAX+1)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin tile; sampled only in IDLE
- k_len  in  KW  beats in tile, latched on start
- acc_mode  in  1  1 = keep accumulators from previous tile; latched on start
- signed_mode  in  1  1 = two's-complement operands; latched on start
- in_valid  in  1  beat present
- in_ready  out  1  tile accepts beat
- a_col  in  DATA_WIDTH*ROWS  A[i][k] at bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
- b_row  in  DATA_WIDTH*COLS  B[k][j] at bits [(j+1)*DATA_WIDTH-1 -: DATA_WIDTH]
- out_valid  out  1  result row present
- out_ready  in  1  consumer takes row
- out_row  out  ACC_WIDTH*COLS  C[r][j] at bits [(j+1)*ACC_WIDTH-1 -: ACC_WIDTH]
- out_row_idx  out  $clog2(ROWS)  r of current row (width min 1)
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse after last row handshake

## Operation
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE: on start, latch k_len, acc_mode and signed_mode.
  - If acc_mode=0, clear all accumulators on this cycle.
  - Go to LOAD if k_len>0; otherwise go to DRAIN.
- LOAD:
  - in_ready=1.
  - Each handshake (in_valid&in_ready) advances the whole array one step and increments the beat counter.
  - With no handshake, the array, skew registers and accumulators hold; stalls inject no bubbles.
  - After the k_len-th handshake, go to FLUSH.
- FLUSH:
  - Array advances every cycle with zero operands fed at the inputs.
  - Lasts exactly ROWS+COLS-1 cycles, then go to DRAIN.
- Skew: row i operand is delayed i steps; column j operand is delayed j steps.
  - PE(i,j) passes a right and b down through registers.
  - Each step: acc += a*b.
  - Final C[i][j] = (acc_mode ? prior C : 0) + Σk A[i][k]*B[k][j].
- Arithmetic:
  - Product is 2*DATA_WIDTH bits, sign- or zero-extended per signed_mode to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH; no saturation, no overflow flag.
- DRAIN:
  - Presents rows r = 0..ROWS-1 in order; out_valid=1 throughout.
  - out_row and out_row_idx are held stable until out_ready.
  - On the handshake of row ROWS-1: go to IDLE and pulse done the next cycle.
- start outside IDLE is ignored. k_len is truncated to KW bits; values > K_MAX are not allowed.
- rst in any state:
  - State goes to IDLE; counters, skew registers and accumulators are zeroed.
  - Outputs take their reset values on the next edge.
  - A partial tile is discarded.

## Timing
- Reset values: in_ready=0, out_valid=0, out_row=0, out_row_idx=0, busy=0, done=0.
- start high in IDLE at edge t:
  - busy=1 and in_ready=1 from t+1.
  - With k_len=0, out_valid=1 from t+1 instead.
- Last beat handshake at edge t:
  - in_ready=0 from t+1.
  - FLUSH occupies t+1..t+ROWS+COLS-1.
  - out_valid=1 from t+ROWS+COLS.
- With out_ready held high, one row per cycle. Last row accepted at edge u gives busy=0 from u+1 and done=1 for cycle u+1 only.
- Minimum tile time: 1 + K + (ROWS+COLS-1) + ROWS cycles.
- Earliest next start: the done cycle.
- Outputs are registered; no combinational path from in_valid or out_ready to any output except none. in_ready and out_valid are state decodes.

## Test plan
Configuration: ROWS=COLS=4, DATA_WIDTH=8, ACC_WIDTH=32 unless stated.
- Ramp:
  - Stimulus: start, k_len=4, signed_mode=0, acc_mode=0; 4 back-to-back beats of a_col=[1,2,3,4], b_row=[1,2,3,4].
  - Response: C[i][j]=4(i+1)(j+1), so C[0][0]=4 and C[3][3]=64.
  - Timing: first out_valid 8 cycles after the last beat; done 4 cycles later with out_ready=1.
- Signedness:
  - Stimulus: k_len=2, all a=0xFD, all b=5.
  - Response with signed_mode=1: every C=0xFFFFFFE2 (−30).
  - Response with signed_mode=0: every C=2530.
- Stalls and back-pressure:
  - Stimulus: ramp test with in_valid deasserted on alternate cycles and out_ready toggling pseudo-randomly.
  - Response: results identical to the ramp test; out_row stable while out_valid&!out_ready; rows in order 0..3.
- Accumulate and busy-ignore:
  - Stimulus: ramp test, then repeat with acc_mode=1.
  - Response: C[3][3]=128. A start pulsed mid-LOAD is ignored.
- Reset mid-tile:
  - Stimulus: assert rst after 2 beats of the ramp test.
  - Response: next cycle busy=0 and in_ready=0. A following ramp tile with acc_mode=1 gives C[3][3]=64, showing accumulators were cleared.
- Empty tile and wrap:
  - Stimulus: k_len=0, acc_mode=0.
  - Response: four zero rows, done.
  - Stimulus: ACC_WIDTH=16, unsigned, k_len=2, a=b=0xFF.
  - Response: C=(2·65025) mod 65536 = 64514.
